// File: rtl/tone_player.sv
// Tone generator: latches a divider code, steps an 8-bit phase every freq_l clocks,
// shapes it into a square/saw/triangle sample and PWM-modulates it onto one pin.
module tone_player #(
   parameter int DUR_CYCLES = 2_000_000,
   parameter int DUR_W      = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] freq_i,
   input  logic [1:0] wave_sel_i,
   output logic [7:0] sample_o,
   output logic       pwm_o,
   output logic       busy_o
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PLAY = 1'b1;

   localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(DUR_CYCLES - 1);

   logic [0:0]       state_q,   state_d;
   logic [7:0]       freq_l_q,  freq_l_d;
   logic [7:0]       div_cnt_q, div_cnt_d;
   logic [7:0]       phase_q,   phase_d;
   logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
   logic [7:0]       pwm_cnt_q, pwm_cnt_d;
   logic [7:0]       sample_q,  sample_d;
   logic             pwm_q,     pwm_d;
   logic             busy_q,    busy_d;

   logic             trigger;
   logic [7:0]       wave;

   assign trigger = (freq_i != 8'd0);

   always_comb begin
      wave = phase_q[7] ? 8'd0 : 8'd255;
      case (wave_sel_i)
         2'd1:    wave = phase_q;
         2'd2:    wave = phase_q[7] ? {~phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
         default: wave = phase_q[7] ? 8'd0 : 8'd255;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      freq_l_d  = freq_l_q;
      div_cnt_d = div_cnt_q;
      phase_d   = phase_q;
      dur_cnt_d = dur_cnt_q;

      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d   = PLAY;
               freq_l_d  = freq_i;
               div_cnt_d = 8'd0;
               phase_d   = 8'd0;
               dur_cnt_d = DUR_LOAD;
            end
         end
         default: begin
            if (div_cnt_q == freq_l_q - 8'd1) begin
               div_cnt_d = 8'd0;
               phase_d   = phase_q + 8'd1;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end

            // A held identical code only extends the note; a new code restarts the waveform.
            if (trigger) begin
               dur_cnt_d = DUR_LOAD;
               if (freq_i != freq_l_q) begin
                  freq_l_d  = freq_i;
                  div_cnt_d = 8'd0;
                  phase_d   = 8'd0;
               end
            end else if (dur_cnt_q != '0) begin
               dur_cnt_d = dur_cnt_q - 1'b1;
            end else begin
               state_d   = IDLE;
               div_cnt_d = 8'd0;
               phase_d   = 8'd0;
            end
         end
      endcase

      pwm_cnt_d = pwm_cnt_q + 8'd1;
      sample_d  = (state_q == PLAY) ? wave : 8'd0;
      pwm_d     = (state_q == PLAY) && (pwm_cnt_q < sample_q);
      busy_d    = (state_q == PLAY);
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is simply the highest-priority branch of the clocked block.
      if (rst) begin
         state_q   <= IDLE;
         freq_l_q  <= 8'd0;
         div_cnt_q <= 8'd0;
         phase_q   <= 8'd0;
         dur_cnt_q <= '0;
         pwm_cnt_q <= 8'd0;
         sample_q  <= 8'd0;
         pwm_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         freq_l_q  <= freq_l_d;
         div_cnt_q <= div_cnt_d;
         phase_q   <= phase_d;
         dur_cnt_q <= dur_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         sample_q  <= sample_d;
         pwm_q     <= pwm_d;
         busy_q    <= busy_d;
      end
   end

   assign sample_o = sample_q;
   assign pwm_o    = pwm_q;
   assign busy_o   = busy_q;

endmodule
